seg_scan_ctrl: RTL

Time-division scheduler that shares one combinational hex-to-7-segment decoder (dec_7seg) across NDIG multiplexed common-anode digits.
- Holds a double-buffered display value and presents one nibble per slot to the decoder.
- Registers the decoded pattern and drives active-low anodes, with an inter-digit blanking interval and optional leading-zero suppression.
- Sits between the system value bus and the board display pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_ctrl_top.sv | 75 +++++++
 rtl/seg_scan_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment scanner.
//   - SEG_BLANK: all segments off (active-low drive)
//   - segment bit order is {a,b,c,d,e,f,g}, a in the MSB
//   - scan_state_t: scanner FSM states
//   - DEF_*: default timing / size constants
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int DEF_NDIG  = 4;
    localparam int DEF_DIV   = 50000;
    localparam int DEF_BLANK = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value-bus side of the display scanner.
//   en      scan enable (0 = display dark)
//   lz_en   leading-zero suppression enable
//   load    one-cycle strobe capturing data_in / dp_in
//   data_in display value, nibble k = digit k (digit 0 = LS nibble)
//   dp_in   decimal point per digit, 1 = lit
//   busy    a loaded value is waiting for the next frame boundary
// master = system side, slave = scanner.
interface seg_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                en;
    logic                lz_en;
    logic                load;
    logic [4*NDIG-1:0]   data_in;
    logic [NDIG-1:0]     dp_in;
    logic                busy;

    modport master (output en, lz_en, load, data_in, dp_in, input busy);
    modport slave  (input en, lz_en, load, data_in, dp_in, output busy);
endinterface

// File: rtl/seg_scan_ctrl_top.sv
// dec_7seg: combinational hex to 7-segment decoder, active-low {a..g}.
//   D   nibble in
//   SEG segment pattern out (0 -> 7'b0000001)
// seg_scan_top: scanner plus its single shared decoder.
//   clk, rst_n      clock / async active-low reset
//   bus             value bus (slave side)
//   frame_done      one-cycle pulse after the last digit slot
//   seg_n/dp_n/an_n registered board display pins
module dec_7seg
    import seg_pkg::*;
(
    input  logic [3:0] D,
    output logic [6:0] SEG
);
    always_comb begin
        SEG = SEG_BLANK;
        case (D)
            4'h0: SEG = 7'b0000001;
            4'h1: SEG = 7'b1001111;
            4'h2: SEG = 7'b0010010;
            4'h3: SEG = 7'b0000110;
            4'h4: SEG = 7'b1001100;
            4'h5: SEG = 7'b0100100;
            4'h6: SEG = 7'b0100000;
            4'h7: SEG = 7'b0001101;
            4'h8: SEG = 7'b0000000;
            4'h9: SEG = 7'b0000100;
            4'hA: SEG = 7'b0001000;
            4'hB: SEG = 7'b1100000;
            4'hC: SEG = 7'b0110001;
            4'hD: SEG = 7'b1000010;
            4'hE: SEG = 7'b0110000;
            4'hF: SEG = 7'b0111000;
            default: SEG = SEG_BLANK;
        endcase
    end
endmodule

module seg_scan_top #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus,
    output logic            frame_done,
    output logic [6:0]      seg_n,
    output logic            dp_n,
    output logic [NDIG-1:0] an_n
);
    logic [3:0] dig_code;
    logic [6:0] seg_dec;

    seg_scan_ctrl #(
        .NDIG  (NDIG),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_done (frame_done),
        .dig_code   (dig_code),
        .seg_in     (seg_dec),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n)
    );

    dec_7seg u_dec (
        .D   (dig_code),
        .SEG (seg_dec)
    );
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-division scanner for NDIG common-anode digits
// sharing one external hex decoder.
//   clk, rst_n  clock / async active-low reset
//   bus         value bus (slave): en, lz_en, load, data_in, dp_in, busy
//   frame_done  one-cycle pulse after the last digit slot of a frame
//   dig_code    nibble presented to the shared decoder
//   seg_in      decoder output, active-low {a..g}
//   seg_n, dp_n, an_n  registered display drive, all active-low
// Each digit slot is DIV cycles: BLANK dark cycles, then SHOW cycles.
// A loaded value waits in a pending buffer and is committed only at a
// frame boundary so a frame never mixes old and new digits.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG  = DEF_NDIG,
    parameter int DIV   = DEF_DIV,
    parameter int BLANK = DEF_BLANK
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus,
    output logic            frame_done,
    output logic [3:0]      dig_code,
    input  logic [6:0]      seg_in,
    output logic [6:0]      seg_n,
    output logic            dp_n,
    output logic [NDIG-1:0] an_n
);
    localparam int IDX_W = $clog2(NDIG);
    localparam int CNT_W = $clog2(DIV);

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4*NDIG-1:0] active_q, active_d;
    logic [NDIG-1:0]   active_dp_q, active_dp_d;
    logic [4*NDIG-1:0] pend_q, pend_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
    logic              pend_vld_q, pend_vld_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              dp_n_q, dp_n_d;
    logic [NDIG-1:0]   an_n_q, an_n_d;
    logic [3:0]        dig_code_q, dig_code_d;
    logic              frame_done_q, frame_done_d;

    logic              last_slot_end;
    logic              commit;
    logic [3:0]        nib_d [NDIG];
    logic [NDIG-1:0]   hi_zero;

    // nib_d: digits of the value that will be active next cycle, so the
    // nibble latched at a frame start already reflects the commit.
    // hi_zero[k]: digits k..NDIG-1 of the active value are all zero.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign nib_d[gi]   = active_d[4*gi +: 4];
        assign hi_zero[gi] = (active_q[4*NDIG-1:4*gi] == '0);
    end

    assign last_slot_end = (state_q == ST_SHOW) &&
                           (cnt_q == CNT_W'(DIV-1)) &&
                           (idx_q == IDX_W'(NDIG-1));

    // IDLE commits every cycle so a load while dark takes effect at once.
    assign commit = (state_q == ST_IDLE) || (bus.en && last_slot_end);

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_vld_d   = pend_vld_q;
        seg_n_d      = SEG_BLANK;
        dp_n_d       = 1'b1;
        an_n_d       = '1;
        dig_code_d   = dig_code_q;
        frame_done_d = bus.en && last_slot_end;

        if (!bus.en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BLANK-1)) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_W'(DIV-1)) begin
                        cnt_d   = '0;
                        state_d = ST_BLANK;
                        idx_d   = (idx_q == IDX_W'(NDIG-1)) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Load handshake: a load on the commit cycle bypasses pending.
        if (commit) begin
            if (bus.load) begin
                active_d    = bus.data_in;
                active_dp_d = bus.dp_in;
            end else if (pend_vld_q) begin
                active_d    = pend_q;
                active_dp_d = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.load) begin
            pend_d     = bus.data_in;
            pend_dp_d  = bus.dp_in;
            pend_vld_d = 1'b1;
        end

        // The decoder input changes only on slot entry, giving it the
        // whole blanking interval to settle before seg_in is sampled.
        if (state_d == ST_BLANK && state_q != ST_BLANK) begin
            dig_code_d = nib_d[idx_d];
        end

        if (state_d == ST_SHOW &&
            !(bus.lz_en && idx_d != '0 && hi_zero[idx_d])) begin
            an_n_d[idx_d] = 1'b0;
            seg_n_d       = seg_in;
            dp_n_d        = ~active_dp_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            dig_code_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            dig_code_q   <= dig_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.busy   = pend_vld_q;
    assign frame_done = frame_done_q;
    assign dig_code   = dig_code_q;
    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;

endmodule
